led_strand_decoder: RTL and testbench
=====================================

// Module: led_strand_decoder
// PURPOSE
//  Receive end of the one-wire addressable-LED strand protocol. Samples a strand line,
//  decodes high-pulse widths into bits, assembles GRB pixels (MSB first), presents one
//  pixel per color_valid pulse with its index, and flags frame latch and protocol errors.
//  Used in loopback benches and on-board self-test against the strand transmitter.
// PARAMETERS
//  NUM_LEDS          2     pixels per frame; pixels beyond this set overflow, not reported
//  BIT_THRESH_CYCLES 60    high width >= this decodes 1, else 0 (100 MHz: T0H 40, T1H 80)
//  MIN_HIGH_CYCLES   10    high width < this is a glitch; ignored, no bit
//  MAX_HIGH_CYCLES   150   high width > this is an error; pixel in progress discarded
//  RESET_CYCLES      5000  low time >= this is a latch/reset (50 us @ 100 MHz)
// PORTS
//  clk_in         in   1   system clock (100 MHz)
//  rst_in         in   1   asynchronous, active-low reset
//  strand_in      in   1   strand line, asynchronous to clk_in
//  green_out      out  8   decoded green of last completed pixel
//  red_out        out  8   decoded red of last completed pixel
//  blue_out       out  8   decoded blue of last completed pixel
//  led_index      out  $clog2(NUM_LEDS)  index (0-based) of pixel on *_out
//  color_valid    out  1   one-cycle pulse: *_out and led_index valid
//  frame_done     out  1   one-cycle pulse on latch after >=1 bit received
//  overflow       out  1   sticky: >NUM_LEDS pixels in current frame; cleared on latch
//  error          out  1   one-cycle pulse: over-long high or partial pixel at latch
// BEHAVIOUR
//  - Reset: all outputs 0; state SYNC; counters, shift register, pixel count cleared.
//  - strand_in passes 2-flop synchronizer; edges detected on synced signal (s).
//  - States:
//    SYNC: wait for s low for RESET_CYCLES consecutive cycles -> IDLE. A high restarts
//          the count. No bits decoded in SYNC (prevents mid-stream misalignment).
//    IDLE: s low; rising edge -> HIGH with high_cnt=1.
//    HIGH: high_cnt++ (saturate at MAX_HIGH_CYCLES+1). If high_cnt>MAX -> error pulse,
//          discard partial pixel, -> SYNC. Falling edge: classify width w; w<MIN ignored;
//          else shift bit into 24-bit reg (MSB first, G[7:0],R[7:0],B[7:0]), bit_cnt++;
//          -> LOW with low_cnt=1.
//    LOW:  low_cnt++ (saturate at RESET_CYCLES). Rising edge -> HIGH. low_cnt reaching
//          RESET_CYCLES = latch: frame_done pulse if any bit this frame; error pulse if
//          bit_cnt!=0; clear bit_cnt, pixel count, overflow; -> IDLE.
//  - 24th bit: if pixel count < NUM_LEDS, drive *_out/led_index and pulse color_valid;
//    else set overflow. bit_cnt wraps to 0, pixel count increments (saturating).
//  - Latency: color_valid rises exactly 3 clk_in cycles after the strand_in falling
//    edge of the 24th bit (2 sync + 1 output reg). frame_done the cycle low_cnt
//    reaches RESET_CYCLES (pin low for RESET_CYCLES+2 cycles).
//  - Width classification counts synchronized cycles inclusive of rising-edge cycle.
//  - *_out/led_index hold between pulses. Same-cycle glitch end + latch cannot occur.
//  - Reset mid-frame: immediate return to SYNC; no pulses emitted.
// TESTING
//  1 Reset, line low 5000 cyc, then 24 bits of 0x12_34_56 (T0H=40/T1H=80, period 125)
//    -> color_valid once: green=0x12 red=0x34 blue=0x56 led_index=0, 3 cyc after edge.
//  2 Two pixels 0xFF0000, 0x0000FF then 6000 cyc low -> index 0 then 1, frame_done 1x,
//    error 0.
//  3 Three pixels with NUM_LEDS=2 -> two color_valid, overflow=1 after 72nd bit,
//    cleared at latch.
//  4 5-cyc high glitch inside bit stream -> ignored, pixel decodes correctly;
//    200-cyc high -> error pulse, no color_valid, SYNC until 5000 cyc low.
//  5 12 bits then 6000 cyc low -> error and frame_done pulse, no color_valid;
//    next frame decodes from index 0.
//  6 Bits start without prior low period, and rst_in low mid-pixel -> no output until
//    RESET_CYCLES low observed; all outputs 0 during reset.

Source files
------------

// File: rtl/led_strand_decoder.sv
// Receive side of the one-wire addressable-LED strand: measures synchronized high-pulse widths,
// assembles GRB pixels MSB first and reports each pixel, frame latches and protocol errors.
module led_strand_decoder #(
    parameter int unsigned NUM_LEDS          = 2,
    parameter int unsigned BIT_THRESH_CYCLES = 60,
    parameter int unsigned MIN_HIGH_CYCLES   = 10,
    parameter int unsigned MAX_HIGH_CYCLES   = 150,
    parameter int unsigned RESET_CYCLES      = 5000,
    localparam int unsigned IdxW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            strand_in,
    output logic [7:0]      green_out,
    output logic [7:0]      red_out,
    output logic [7:0]      blue_out,
    output logic [IdxW-1:0] led_index,
    output logic            color_valid,
    output logic            frame_done,
    output logic            overflow,
    output logic            error
);

    localparam int unsigned HighW = $clog2(MAX_HIGH_CYCLES + 2);
    localparam int unsigned LowW  = $clog2(RESET_CYCLES + 1);
    localparam int unsigned PixW  = $clog2(NUM_LEDS + 1);

    localparam logic [HighW-1:0] HighMax   = HighW'(MAX_HIGH_CYCLES);
    localparam logic [HighW-1:0] HighMin   = HighW'(MIN_HIGH_CYCLES);
    localparam logic [HighW-1:0] HighOne   = HighW'(BIT_THRESH_CYCLES);
    localparam logic [LowW-1:0]  LowLast   = LowW'(RESET_CYCLES - 1);
    localparam logic [PixW-1:0]  PixMax    = PixW'(NUM_LEDS);

    typedef enum logic [1:0] {StSync, StIdle, StHigh, StLow} state_e;

    state_e            state_q, state_d;
    logic              sync1_q, strand_q;
    logic [HighW-1:0]  high_cnt_q, high_cnt_d;
    logic [LowW-1:0]   low_cnt_q, low_cnt_d;
    logic [22:0]       shift_q, shift_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [PixW-1:0]   pix_cnt_q, pix_cnt_d;
    logic              any_bit_q, any_bit_d;
    logic [7:0]        green_q, green_d, red_q, red_d, blue_q, blue_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              valid_q, valid_d, done_q, done_d, ovf_q, ovf_d, err_q, err_d;

    logic              bit_val;
    logic [23:0]       pixel_nxt;

    assign bit_val   = (high_cnt_q >= HighOne);
    assign pixel_nxt = {shift_q, bit_val};

    always_comb begin
        state_d    = state_q;
        high_cnt_d = high_cnt_q;
        low_cnt_d  = low_cnt_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        any_bit_d  = any_bit_q;
        green_d    = green_q;
        red_d      = red_q;
        blue_d     = blue_q;
        idx_d      = idx_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            // Only a full reset-length low run aligns us to a frame boundary.
            StSync: begin
                if (strand_q) begin
                    low_cnt_d = '0;
                end else if (low_cnt_q == LowLast) begin
                    state_d   = StIdle;
                    low_cnt_d = '0;
                    bit_cnt_d = '0;
                    pix_cnt_d = '0;
                    any_bit_d = 1'b0;
                    ovf_d     = 1'b0;
                end else begin
                    low_cnt_d = low_cnt_q + 1'b1;
                end
            end
            StIdle: begin
                if (strand_q) begin
                    state_d    = StHigh;
                    high_cnt_d = HighW'(1);
                end
            end
            StHigh: begin
                if (high_cnt_q > HighMax) begin
                    err_d     = 1'b1;
                    bit_cnt_d = '0;
                    low_cnt_d = '0;
                    state_d   = StSync;
                end else if (!strand_q) begin
                    state_d   = StLow;
                    low_cnt_d = LowW'(1);
                    if (high_cnt_q >= HighMin) begin
                        shift_d   = pixel_nxt[22:0];
                        any_bit_d = 1'b1;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d = '0;
                            if (pix_cnt_q < PixMax) begin
                                green_d = pixel_nxt[23:16];
                                red_d   = pixel_nxt[15:8];
                                blue_d  = pixel_nxt[7:0];
                                idx_d   = IdxW'(pix_cnt_q);
                                valid_d = 1'b1;
                            end else begin
                                ovf_d = 1'b1;
                            end
                            if (pix_cnt_q != PixMax) begin
                                pix_cnt_d = pix_cnt_q + 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end else begin
                    high_cnt_d = high_cnt_q + 1'b1;
                end
            end
            StLow: begin
                if (strand_q) begin
                    state_d    = StHigh;
                    high_cnt_d = HighW'(1);
                end else if (low_cnt_q == LowLast) begin
                    done_d    = any_bit_q;
                    err_d     = (bit_cnt_q != '0);
                    bit_cnt_d = '0;
                    pix_cnt_d = '0;
                    any_bit_d = 1'b0;
                    ovf_d     = 1'b0;
                    low_cnt_d = '0;
                    state_d   = StIdle;
                end else begin
                    low_cnt_d = low_cnt_q + 1'b1;
                end
            end
            default: state_d = StSync;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sync1_q    <= 1'b0;
            strand_q   <= 1'b0;
            state_q    <= StSync;
            high_cnt_q <= '0;
            low_cnt_q  <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            pix_cnt_q  <= '0;
            any_bit_q  <= 1'b0;
            green_q    <= '0;
            red_q      <= '0;
            blue_q     <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sync1_q    <= strand_in;
            strand_q   <= sync1_q;
            state_q    <= state_d;
            high_cnt_q <= high_cnt_d;
            low_cnt_q  <= low_cnt_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            any_bit_q  <= any_bit_d;
            green_q    <= green_d;
            red_q      <= red_d;
            blue_q     <= blue_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
        end
    end

    assign green_out   = green_q;
    assign red_out     = red_q;
    assign blue_out    = blue_q;
    assign led_index   = idx_q;
    assign color_valid = valid_q;
    assign frame_done  = done_q;
    assign overflow    = ovf_q;
    assign error       = err_q;

endmodule

// File: tb/tb_led_strand_decoder.sv
// Bench for led_strand_decoder: drives strand waveforms, scoreboards expected pixels and
// counts frame_done/error pulses against expectations.
module tb_led_strand_decoder;

    localparam int LATCH = 5300;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       strand_in = 1'b0;
    logic [7:0] green_out, red_out, blue_out;
    logic       led_index;
    logic       color_valid, frame_done, overflow, error;

    led_strand_decoder dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .strand_in   (strand_in),
        .green_out   (green_out),
        .red_out     (red_out),
        .blue_out    (blue_out),
        .led_index   (led_index),
        .color_valid (color_valid),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .error       (error)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [23:0] grb;
        int          idx;
        int          fall_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_frame = 0;
    int   n_err = 0;
    int   exp_frame = 0;
    int   exp_err = 0;
    int   frame_pix = 0;
    bit   expect_out = 1'b1;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk_in) begin
        if (color_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious color_valid, queue size", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check_eq("pixel grb", {green_out, red_out, blue_out}, e.grb);
                check_eq("pixel index", led_index, e.idx);
                check_eq("pixel latency", cyc - e.fall_cyc, 3);
            end
        end
        if (frame_done) n_frame++;
        if (error) n_err++;
    end

    // Sends the top n bits of v; a glitch pulse is inserted in the low phase of bit glitch_at.
    task automatic send_bits(input logic [23:0] v, input int n, input int glitch_at);
        for (int i = 0; i < n; i++) begin
            logic b;
            int   lo;
            b = v[23-i];
            lo = b ? 45 : 85;
            strand_in = 1'b1;
            repeat (b ? 80 : 40) @(negedge clk_in);
            strand_in = 1'b0;
            if (i == 23) begin
                if (expect_out && frame_pix < 2) exp_q.push_back('{v, frame_pix, cyc});
                frame_pix++;
            end
            if (i == glitch_at) begin
                repeat (20) @(negedge clk_in);
                strand_in = 1'b1;
                repeat (5) @(negedge clk_in);
                strand_in = 1'b0;
                lo = lo - 25;
            end
            repeat (lo) @(negedge clk_in);
        end
    endtask

    task automatic latch_low(input int n);
        strand_in = 1'b0;
        repeat (n) @(negedge clk_in);
        frame_pix = 0;
    endtask

    task automatic check_counts(input string tag);
        check_eq({tag, " frame_done count"}, n_frame, exp_frame);
        check_eq({tag, " error count"}, n_err, exp_err);
        check_eq({tag, " pending pixels"}, exp_q.size(), 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk_in);
        check_eq("reset outputs",
                 {green_out, red_out, blue_out, led_index, color_valid, frame_done, overflow,
                  error}, 0);
        rst_in = 1'b1;
        repeat (5050) @(negedge clk_in);

        // Single pixel
        send_bits(24'h123456, 24, -1);
        latch_low(LATCH);
        exp_frame++;
        check_counts("t1");
        check_eq("t1 held grb", {green_out, red_out, blue_out}, 24'h123456);

        // Two pixels, one frame
        send_bits(24'hFF0000, 24, -1);
        send_bits(24'h0000FF, 24, -1);
        latch_low(LATCH);
        exp_frame++;
        check_counts("t2");
        check_eq("t2 held index", led_index, 1);

        // Three pixels overflow a two-LED frame
        send_bits(24'hAA5501, 24, -1);
        send_bits(24'h01AA55, 24, -1);
        check_eq("t3 overflow before third", overflow, 0);
        send_bits(24'h5501AA, 24, -1);
        check_eq("t3 overflow after third", overflow, 1);
        latch_low(LATCH);
        exp_frame++;
        check_eq("t3 overflow cleared", overflow, 0);
        check_counts("t3");

        // Short glitch is ignored
        send_bits(24'hA5C30F, 24, 5);
        latch_low(LATCH);
        exp_frame++;
        check_counts("t4a");

        // Over-long high: error, then resync required
        send_bits(24'hF0F0F0, 8, -1);
        strand_in = 1'b1;
        repeat (200) @(negedge clk_in);
        strand_in = 1'b0;
        repeat (10) @(negedge clk_in);
        exp_err++;
        check_eq("t4b error count", n_err, exp_err);
        expect_out = 1'b0;
        send_bits(24'h00FF00, 24, -1);
        expect_out = 1'b1;
        latch_low(LATCH);
        check_counts("t4b");

        // Partial pixel at latch
        send_bits(24'hABCDEF, 12, -1);
        latch_low(LATCH);
        exp_frame++;
        exp_err++;
        check_counts("t5");
        send_bits(24'h112233, 24, -1);
        repeat (5) @(negedge clk_in);
        check_counts("t5 next");

        // Reset with held outputs, then bits with no prior low period
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check_eq("t6 outputs in reset",
                 {green_out, red_out, blue_out, led_index, color_valid, frame_done, overflow,
                  error}, 0);
        rst_in = 1'b1;
        expect_out = 1'b0;
        send_bits(24'hFFFFFF, 24, -1);
        send_bits(24'hF0F0F0, 10, -1);
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check_eq("t6 outputs in mid-pixel reset",
                 {green_out, red_out, blue_out, led_index, color_valid, frame_done, overflow,
                  error}, 0);
        rst_in = 1'b1;
        send_bits(24'h0F0F0F, 14, -1);
        check_counts("t6 no output");
        expect_out = 1'b1;
        latch_low(LATCH);
        send_bits(24'h0A0B0C, 24, -1);
        repeat (5) @(negedge clk_in);
        check_counts("t6 final");
        check_eq("t6 final grb", {green_out, red_out, blue_out}, 24'h0A0B0C);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
